chacha_keyslot_loader: RTL and testbench

CHACHA_KEYSLOT_LOADER -- requirements
Module: chacha_keyslot_loader

---
 rtl/chacha_loader_pkg.sv | 36 +++
 rtl/chacha_keyslot_loader_bank.sv | 67 ++++++
 rtl/chacha_keyslot_loader.sv | 173 +++++++++++++++++
 tb/tb_chacha_keyslot_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_loader_pkg.sv
// chacha_loader_pkg -- shared constants and types for the ChaCha key-slot loader.
//   * command opcodes carried in bits [7:6] of the first byte of a frame
//   * loader FSM state enum
//   * slot record geometry: 48 bytes = key (32) + nonce (12) + position (4),
//     frame byte k lives at record bits [8k+:8]
package chacha_loader_pkg;

  localparam int FRAME_BYTES = 48;
  localparam int REC_W       = 8 * FRAME_BYTES;  // 384-bit slot record
  localparam int CNT_W       = 6;                // byte counter, 0..47
  localparam int KEY_W       = 256;
  localparam int NONCE_W     = 96;
  localparam int POS_W       = 32;
  localparam int NONCE_LSB   = KEY_W;
  localparam int POS_LSB     = KEY_W + NONCE_W;
  localparam int KEY_BYTES   = KEY_W / 8;        // bytes hidden when readback is off

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_DISCARD
  } state_t;

  // Byte idx of a little-endian record.
  function automatic logic [7:0] rec_byte(input logic [REC_W-1:0] rec,
                                          input logic [CNT_W-1:0] idx);
    return rec[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/chacha_keyslot_loader_bank.sv
// keyslot_bank -- storage for NUM_SLOTS key/nonce/position records.
//   clk, rst        : clock, asynchronous active-high reset (clears every slot)
//   wr_en/wr_slot/wr_data : full-record write port, one whole record per cycle
//   act_slot/act_rec      : read port for the active slot (drives the cipher)
//   rd_slot/rd_idx/rd_byte: byte tap of any slot for frame readback
//   inc_en          : advance the active slot's position by one (mod 2^32)
//   wrap_evt        : combinational, this increment takes position 0xFFFFFFFF -> 0
module keyslot_bank
  import chacha_loader_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [REC_W-1:0]  wr_data,
  input  logic [SLOT_W-1:0] act_slot,
  output logic [REC_W-1:0]  act_rec,
  input  logic [SLOT_W-1:0] rd_slot,
  input  logic [CNT_W-1:0]  rd_idx,
  output logic [7:0]        rd_byte,
  input  logic              inc_en,
  output logic              wrap_evt
);

  logic [REC_W-1:0] slots [NUM_SLOTS];
  logic [REC_W-1:0] rd_rec;
  logic             commit_hits_active;

  // NOTE: every output of a combinational block gets a default before the
  // selection loop; otherwise an unmatched index would infer a latch.
  always_comb begin
    act_rec = '0;
    rd_rec  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (act_slot == SLOT_W'(i)) act_rec = slots[i];
      if (rd_slot  == SLOT_W'(i)) rd_rec  = slots[i];
    end
  end

  assign rd_byte = rec_byte(rd_rec, rd_idx);

  // A commit to the active slot overrides a same-cycle increment, so the
  // increment (and any wrap it would have caused) is lost.
  assign commit_hits_active = wr_en && (wr_slot == act_slot);
  assign wrap_evt = inc_en && !commit_hits_active &&
                    (act_rec[POS_LSB +: POS_W] == '1);

  // NOTE: the slot array is reset explicitly: key material must read as
  // zero after reset, so this storage cannot be left as uninitialised RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en && wr_slot == SLOT_W'(i)) begin
          slots[i] <= wr_data;
        end else if (inc_en && act_slot == SLOT_W'(i)) begin
          slots[i][POS_LSB +: POS_W] <= slots[i][POS_LSB +: POS_W] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/chacha_keyslot_loader.sv
// chacha_keyslot_loader -- SPI-frame command parser that loads, reads back and
// selects ChaCha key/nonce/position slots.
//   clk, rst                 : clock, asynchronous active-high reset
//   rx_dv, rx_byte           : received MOSI byte strobe from the SPI slave
//   frame_end                : chip-select release pulse, aborts any frame
//   tx_dv, tx_byte           : MISO byte strobe back to the SPI slave
//   blk_done                 : cipher finished one block, advance position
//   key, nonce, position     : active slot record (combinational from bank)
//   start                    : one-cycle cipher start pulse after START
//   active_slot              : slot currently driving key/nonce/position
//   pos_wrap                 : sticky, active slot position wrapped to zero
//   cmd_err                  : one-cycle pulse on a command naming a bad slot
// Build option: define KEYSLOT_READBACK_EN to let READ return the key bytes;
// without it READ returns 0x00 for record bytes 0..31 (same tx_dv timing).
module chacha_keyslot_loader
  import chacha_loader_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  input  logic              frame_end,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              blk_done,
  output logic [KEY_W-1:0]  key,
  output logic [NONCE_W-1:0] nonce,
  output logic [POS_W-1:0]  position,
  output logic              start,
  output logic [SLOT_W-1:0] active_slot,
  output logic              pos_wrap,
  output logic              cmd_err
);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [SLOT_W-1:0]   tgt_slot;
  logic [REC_W-1:0]    staging;

  logic [1:0]          opcode;
  logic [SLOT_W-1:0]   cmd_slot;
  logic                slot_ok;
  logic                byte_in;
  logic                last_byte;
  logic                commit;
  logic [REC_W-1:0]    commit_data;
  logic [REC_W-1:0]    act_rec;
  logic [7:0]          rd_byte;
  logic [7:0]          rd_out;
  logic                wrap_evt;

  assign opcode    = rx_byte[7:6];
  assign cmd_slot  = rx_byte[SLOT_W-1:0];
  assign slot_ok   = 32'(rx_byte[3:0]) < NUM_SLOTS;
  // frame_end beats a coincident byte, so the byte is simply dropped.
  assign byte_in   = rx_dv && !frame_end;
  assign last_byte = cnt == CNT_W'(FRAME_BYTES - 1);

  // The final byte goes straight into the committed record, so the slot is
  // updated on the very edge that accepts byte 48.
  assign commit      = byte_in && (state == ST_WR_DATA) && last_byte;
  assign commit_data = {rx_byte, staging[REC_W-9:0]};

  keyslot_bank #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (commit),
    .wr_slot  (tgt_slot),
    .wr_data  (commit_data),
    .act_slot (active_slot),
    .act_rec  (act_rec),
    .rd_slot  (tgt_slot),
    .rd_idx   (cnt),
    .rd_byte  (rd_byte),
    .inc_en   (blk_done),
    .wrap_evt (wrap_evt)
  );

  assign key      = act_rec[KEY_W-1:0];
  assign nonce    = act_rec[NONCE_LSB +: NONCE_W];
  assign position = act_rec[POS_LSB +: POS_W];

`ifdef KEYSLOT_READBACK_EN
  assign rd_out = rd_byte;
`else
  assign rd_out = (cnt < CNT_W'(KEY_BYTES)) ? 8'h00 : rd_byte;
`endif

  // NOTE: all state here is assigned with <= so every branch sees the values
  // from before the edge; blocking = would leak updates between statements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      tgt_slot    <= '0;
      staging     <= '0;
      active_slot <= '0;
      start       <= 1'b0;
      tx_dv       <= 1'b0;
      tx_byte     <= 8'h00;
      cmd_err     <= 1'b0;
      pos_wrap    <= 1'b0;
    end else begin
      start   <= 1'b0;
      tx_dv   <= 1'b0;
      cmd_err <= 1'b0;
      if (wrap_evt) pos_wrap <= 1'b1;

      if (frame_end) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (rx_dv) begin
        unique case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (opcode != OP_NOP && !slot_ok) begin
              cmd_err <= 1'b1;
              state   <= ST_DISCARD;
            end else begin
              unique case (opcode)
                OP_WRITE: begin
                  tgt_slot <= cmd_slot;
                  state    <= ST_WR_DATA;
                end
                OP_READ: begin
                  tgt_slot <= cmd_slot;
                  state    <= ST_RD_DATA;
                end
                OP_START: begin
                  active_slot <= cmd_slot;
                  start       <= 1'b1;
                  pos_wrap    <= 1'b0;
                end
                OP_NOP: ;
              endcase
            end
          end

          ST_WR_DATA: begin
            staging[{cnt, 3'b000} +: 8] <= rx_byte;
            if (last_byte) begin
              state <= ST_IDLE;
              cnt   <= '0;
              if (tgt_slot == active_slot) pos_wrap <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          ST_RD_DATA: begin
            tx_dv   <= 1'b1;
            tx_byte <= rd_out;
            if (last_byte) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          ST_DISCARD: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chacha_keyslot_loader.sv
module tb_chacha_keyslot_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_dv;
  logic [7:0]   rx_byte;
  logic         frame_end;
  logic         tx_dv;
  logic [7:0]   tx_byte;
  logic         blk_done;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  position;
  logic         start;
  logic [1:0]   active_slot;
  logic         pos_wrap;
  logic         cmd_err;

  int n_vec = 0;
  int n_bad = 0;
  int tx_cnt = 0;
  logic [7:0] rec_buf [48];

  chacha_keyslot_loader dut (
    .clk         (clk),
    .rst         (rst),
    .rx_dv       (rx_dv),
    .rx_byte     (rx_byte),
    .frame_end   (frame_end),
    .tx_dv       (tx_dv),
    .tx_byte     (tx_byte),
    .blk_done    (blk_done),
    .key         (key),
    .nonce       (nonce),
    .position    (position),
    .start       (start),
    .active_slot (active_slot),
    .pos_wrap    (pos_wrap),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_dv) tx_cnt++;

  typedef struct {
    logic [7:0] cmd;
    logic       exp_start;
    logic       exp_err;
    logic [1:0] exp_active;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Byte presented for one cycle; returns on the following falling edge,
  // when registered responses to that byte are visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic pulse_frame_end();
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic pulse_blk_done();
    @(negedge clk);
    blk_done = 1'b1;
    @(negedge clk);
    blk_done = 1'b0;
  endtask

  task automatic send_rec(input int n);
    for (int i = 0; i < n; i++) send_byte(rec_buf[i]);
  endtask

  initial begin
    vecs[0] = '{8'hC0, 1'b0, 1'b0, 2'd0};  // NOP
    vecs[1] = '{8'h81, 1'b1, 1'b0, 2'd1};  // START 1
    vecs[2] = '{8'h0F, 1'b0, 1'b1, 2'd1};  // WRITE slot 15: bad
    vecs[3] = '{8'h4A, 1'b0, 1'b1, 2'd1};  // READ slot 10: bad
    vecs[4] = '{8'h84, 1'b0, 1'b1, 2'd1};  // START slot 4: bad
    vecs[5] = '{8'hB2, 1'b1, 1'b0, 2'd2};  // START 2, bits [5:4] ignored
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 2'd2};  // NOP with slot 15: no error
    vecs[7] = '{8'h43, 1'b0, 1'b0, 2'd2};  // READ 3: valid, no pulse
    vecs[8] = '{8'h80, 1'b1, 1'b0, 2'd0};  // START 0

    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; frame_end = 1'b0; blk_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_key", key, '0);
    check("rst_nonce", 256'(nonce), '0);
    check("rst_position", 256'(position), '0);
    check("rst_outs", 256'({start, tx_dv, cmd_err, pos_wrap, active_slot, tx_byte}), '0);

    // Single-command table
    foreach (vecs[v]) begin
      send_byte(vecs[v].cmd);
      check($sformatf("v%0d_start", v), 256'(start), 256'(vecs[v].exp_start));
      check($sformatf("v%0d_err", v), 256'(cmd_err), 256'(vecs[v].exp_err));
      check($sformatf("v%0d_active", v), 256'(active_slot), 256'(vecs[v].exp_active));
      pulse_frame_end();
    end

    // Write slot 1 with 0x00..0x2F while slot 1 is active
    send_byte(8'h81);
    for (int i = 0; i < 48; i++) rec_buf[i] = 8'(i);
    send_byte(8'h01);
    send_rec(47);
    check("wr_atomic_47", key, '0);
    send_byte(rec_buf[47]);
    check("wr_key_w0", 256'(key[31:0]), 256'(32'h03020100));
    check("wr_key_w7", 256'(key[255:224]), 256'(32'h1F1E1D1C));
    check("wr_nonce_w0", 256'(nonce[31:0]), 256'(32'h23222120));
    check("wr_position", 256'(position), 256'(32'h2F2E2D2C));
    for (int s = 0; s < 4; s++) begin
      if (s != 1) begin
        send_byte(8'h80 | 8'(s));
        check($sformatf("other_slot%0d", s), key | 256'(position) | 256'(nonce), '0);
      end
    end

    // Aborted write to slot 2, then START 2 in the same idle parser
    send_byte(8'h02);
    send_rec(20);
    pulse_frame_end();
    send_byte(8'h82);
    check("abort_start", 256'(start), 256'(1));
    check("abort_active", 256'(active_slot), 256'(2));
    check("abort_slot2", key | 256'(position), '0);
    @(negedge clk);
    check("abort_start_once", 256'(start), 256'(0));

    // Position wrap on slot 1
    for (int i = 44; i < 48; i++) rec_buf[i] = 8'hFF;
    send_byte(8'h01);
    send_rec(48);
    send_byte(8'h81);
    check("wrap_pre_pos", 256'(position), 256'(32'hFFFFFFFF));
    check("wrap_pre_flag", 256'(pos_wrap), 256'(0));
    pulse_blk_done();
    check("wrap_pos0", 256'(position), 256'(0));
    check("wrap_flag", 256'(pos_wrap), 256'(1));
    pulse_blk_done();
    check("wrap_pos1", 256'(position), 256'(1));
    check("wrap_sticky", 256'(pos_wrap), 256'(1));

    // Commit to active slot coincident with blk_done: commit wins
    rec_buf[44] = 8'h10;
    for (int i = 45; i < 48; i++) rec_buf[i] = 8'h00;
    send_byte(8'h01);
    send_rec(47);
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = rec_buf[47]; blk_done = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0; blk_done = 1'b0;
    check("race_position", 256'(position), 256'(32'h10));
    check("race_wrap_clr", 256'(pos_wrap), 256'(0));

    // Readback of slot 1
    send_byte(8'h41);
    check("rd_cmd_no_tx", 256'(tx_dv), 256'(0));
    tx_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      logic [7:0] exp_b;
`ifdef KEYSLOT_READBACK_EN
      exp_b = rec_buf[i];
`else
      exp_b = (i < 32) ? 8'h00 : rec_buf[i];
`endif
      send_byte(8'hA5);
      check($sformatf("rd_dv%0d", i), 256'(tx_dv), 256'(1));
      check($sformatf("rd_byte%0d", i), 256'(tx_byte), 256'(exp_b));
    end
    send_byte(8'h80);
    check("rd_tx_count", 256'(tx_cnt), 256'(48));
    check("rd_then_cmd", 256'(start), 256'(1));
    check("rd_then_no_tx", 256'(tx_dv), 256'(0));

    // Bad slot: rest of frame discarded
    send_byte(8'h0F);
    check("disc_err", 256'(cmd_err), 256'(1));
    send_byte(8'h81);
    check("disc_no_start", 256'(start), 256'(0));
    check("disc_active", 256'(active_slot), 256'(0));
    send_byte(8'h0F);
    check("disc_no_err", 256'(cmd_err), 256'(0));
    pulse_frame_end();
    send_byte(8'h81);
    check("disc_recover", 256'(start), 256'(1));

    // frame_end and rx_dv together: byte dropped
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = 8'h82; frame_end = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0; frame_end = 1'b0;
    check("fe_wins_start", 256'(start), 256'(0));
    check("fe_wins_active", 256'(active_slot), 256'(1));

    // Asynchronous reset in the middle of a write to slot 3
    send_byte(8'h03);
    send_rec(30);
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = rec_buf[30];
    #2 rst = 1'b1;
    #1;
    check("arst_key", key, '0);
    check("arst_position", 256'(position), '0);
    check("arst_outs", 256'({start, tx_dv, cmd_err, pos_wrap, active_slot, tx_byte}), '0);
    rx_dv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h83);
    check("arst_cmd_start", 256'(start), 256'(1));
    check("arst_active", 256'(active_slot), 256'(3));
    check("arst_slot3", key | 256'(position), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
